// File: rtl/aes_inv_pkg.sv
// rtl/aes_inv_pkg.sv - AES-128 inverse cipher constants, FSM encoding and GF(2^8)/S-box helpers
package aes_inv_pkg;

  localparam int         NR     = 10;
  localparam logic [3:0] NR_CNT = 4'(NR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_LAST,
    ST_DONE
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^k), k=1..7; maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one schedule step: recover words 3..1 first, then word 0 from the recovered word 3
  function automatic logic [127:0] key_step_back(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
// last_i bypasses InvMixColumns for the final round.
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sub_w;
  logic [127:0] ark_w;
  logic [127:0] mix_w;

  // Byte b = row + 4*col; row r rotates right by r columns
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign sub_w[127-8*(r+4*c) -: 8] = inv_sbox(state_i[127-8*SRC -: 8]);
    end
  end

  assign ark_w = sub_w ^ rkey_i;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_w[127-32*c -: 8];
    assign a1 = ark_w[119-32*c -: 8];
    assign a2 = ark_w[111-32*c -: 8];
    assign a3 = ark_w[103-32*c -: 8];
    assign mix_w[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };
  end

  assign state_o = last_i ? ark_w : mix_w;

endmodule

// File: rtl/aes_inv_core.sv
// rtl/aes_inv_core.sv - AES-128 decryption core, one round per clock, on-the-fly backward key schedule
// Optional AES_INV_KEYCACHE_EN keeps the last rk10 and its cipher key so a repeated key skips KEYEXP.
module aes_inv_core
  import aes_inv_pkg::*;
(
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iStAes,
  input  logic [127:0] iAesKey,
  input  logic [127:0] iCpText,
  output logic         oAesDone,
  output logic [127:0] oPlainText,
  output logic         oBusy
);

  aes_state_e   st_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [127:0] pt_q;
  logic [3:0]   rnd_q;
  logic         done_q;
  logic         busy_q;

  logic [127:0] key_fwd_w;
  logic [127:0] key_back_w;
  logic [127:0] round_w;
  logic         last_w;

  assign key_fwd_w  = key_step_fwd(key_q, rcon(rnd_q + 4'd1));
  assign key_back_w = key_step_back(key_q, rcon(rnd_q));
  assign last_w     = (st_q == ST_LAST);

  aes_inv_round u_round (
    .state_i (state_q),
    .rkey_i  (key_q),
    .last_i  (last_w),
    .state_o (round_w)
  );

`ifdef AES_INV_KEYCACHE_EN
  logic         cache_vld_q;
  logic [127:0] cache_key_q;
  logic [127:0] cache_rk_q;
  logic         cache_hit;
  assign cache_hit = cache_vld_q && (iAesKey == cache_key_q);
`endif

  always_ff @(posedge iClk) begin
    if (iRsn) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AES_INV_KEYCACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (iStAes) begin
            busy_q  <= 1'b1;
            state_q <= iCpText;
`ifdef AES_INV_KEYCACHE_EN
            if (cache_hit) begin
              key_q <= cache_rk_q;
              rnd_q <= NR_CNT;
              st_q  <= ST_INIT;
            end else begin
              key_q       <= iAesKey;
              rnd_q       <= 4'd0;
              st_q        <= ST_KEYEXP;
              cache_key_q <= iAesKey;
              cache_vld_q <= 1'b0;
            end
`else
            key_q <= iAesKey;
            rnd_q <= 4'd0;
            st_q  <= ST_KEYEXP;
`endif
          end
        end
        ST_KEYEXP: begin
          key_q <= key_fwd_w;
          if (rnd_q != NR_CNT) rnd_q <= rnd_q + 4'd1;
          if (rnd_q == NR_CNT - 4'd1) begin
            st_q <= ST_INIT;
`ifdef AES_INV_KEYCACHE_EN
            cache_rk_q  <= key_fwd_w;
            cache_vld_q <= 1'b1;
`endif
          end
        end
        ST_INIT: begin
          state_q <= state_q ^ key_q;
          key_q   <= key_back_w;
          if (rnd_q != 4'd0) rnd_q <= rnd_q - 4'd1;
          st_q    <= ST_ROUND;
        end
        // rnd_q holds i while key_q holds rk_i; stepping back uses Rcon[i]
        ST_ROUND: begin
          state_q <= round_w;
          key_q   <= key_back_w;
          if (rnd_q != 4'd0) rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) st_q <= ST_LAST;
        end
        ST_LAST: begin
          pt_q <= round_w;
          st_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          st_q   <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign oAesDone   = done_q;
  assign oPlainText = pt_q;
  assign oBusy      = busy_q;

endmodule

// File: doc/aes_inv_core.md
AES_INV_CORE -- requirements
Module: aes_inv_core

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 with Nr=10.
REQ-002 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-003 iRsn  input  1  reset, synchronous, active-high.
REQ-004 iStAes  input  1  start pulse; sampled only in IDLE.
REQ-005 iAesKey  input  128  cipher key (round key 0), byte 0 = bits [127:120].
REQ-006 iCpText  input  128  ciphertext block, same byte order as iAesKey.
REQ-007 oAesDone  output  1  one-cycle pulse; oPlainText is valid on this cycle.
REQ-008 oPlainText  output  128  decrypted block; holds its value until the next start.
REQ-009 oBusy  output  1  high from the cycle after a start is accepted through the oAesDone cycle.

Function
REQ-010 The block SHALL implement the FIPS-197 InvCipher for AES-128, one round per clock, bit-exact with the matching encryption core.
REQ-011 FSM states SHALL be IDLE, KEYEXP, INIT, ROUND, LAST, DONE.
REQ-012 In IDLE with iStAes=1, the block SHALL latch iAesKey and iCpText and go to KEYEXP; iStAes in any other state SHALL be ignored.
REQ-013 KEYEXP SHALL run the forward key schedule for 10 cycles and hold round key 10 in the key register at exit.
REQ-014 INIT (1 cycle) SHALL compute state = ciphertext XOR rk10, then step the key register back to rk9.
REQ-015 ROUND (9 cycles, i=9..1) SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk_i), InvMixColumns, and step the key back each cycle.
REQ-016 Backward key step: w'[3..1] = w[j] XOR w[j-1]; w'[0] = w[0] XOR SubWord(RotWord(w'[3])) XOR Rcon[i].
REQ-017 LAST (1 cycle) SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk0) and register the result into oPlainText.
REQ-018 DONE (1 cycle) SHALL assert oAesDone and then return to IDLE; a start can be accepted on the following cycle.
REQ-019 Latency SHALL be exactly 22 cycles from the edge that samples iStAes to the cycle where oAesDone is high.
REQ-020 Rcon SHALL be tracked by a 4-bit round counter indexing a constant table; the counter SHALL NOT wrap beyond 10.
REQ-021 Changes on iAesKey or iCpText after acceptance SHALL NOT affect the current result.

Reset
REQ-022 When iRsn=1 at a clock edge, the block SHALL set: FSM=IDLE, oAesDone=0, oBusy=0, oPlainText=0, state/key registers=0, round counter=0.
REQ-023 A reset in any state, including mid-ROUND, SHALL abort the operation with no oAesDone pulse.
REQ-024 Reset SHALL take priority over iStAes on the same edge.

Configuration
REQ-025 Macro AES_INV_KEYCACHE_EN: when defined, the block SHALL store the last expanded rk10 and its source key.
REQ-026 With the macro, a start whose iAesKey equals the cached key SHALL skip KEYEXP, giving a latency of 12 cycles.
REQ-027 With the macro, reset SHALL clear the cache-valid bit.
REQ-028 Without the macro, there SHALL be no cache storage and latency SHALL always be 22 cycles.

Structure
REQ-029 Package aes_inv_pkg SHALL hold: FSM state encodings, the Rcon table, the SBOX/INV_SBOX functions, GF(2^8) xtime/multiply functions, and the NR=10 constant.
REQ-030 Sub-module aes_inv_round SHALL be the combinational inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns bypass for LAST).
REQ-031 All registers and the FSM SHALL reside in aes_inv_core.

Verification
REQ-032 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, oAesDone exactly 22 cycles after start.
REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-034 A second iStAes pulse during ROUND, plus iCpText changed to all-ones -> result unchanged, exactly one oAesDone pulse.
REQ-035 iRsn asserted at cycle 15 of an operation -> all outputs 0 next cycle, no oAesDone pulse; a new start then decrypts correctly.
REQ-036 With AES_INV_KEYCACHE_EN, back-to-back starts with the same key -> second oAesDone after 12 cycles; after a key change -> 22 cycles.
REQ-037 Loopback: random key and pt through the encryption core and then this block -> output equals pt for 1000 vectors.
